vec_lane_serializer: RTL and testbench

- Consumer of the processor's vector store port (wren_b / data_b).
- Buffers 128-bit vector words in a small FIFO, then streams them out one lane at a time on a valid/ready sample interface.
- The sample interface feeds the audio output sink, i.e. the DAC/sample writer for FIR results.
- Runs in the processor clock domain. Drops words on overflow and flags the loss so firmware can detect it.

---
 rtl/vec_stream_pkg.sv | 17 +
 rtl/vec_sync_fifo.sv | 69 ++++++
 rtl/vec_lane_serializer.sv | 128 ++++++++++++
 tb/tb_vec_lane_serializer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/vec_stream_pkg.sv
// Shared types and constants for the vector-store to audio-lane streaming path.
// The processor store port is 128 bits wide and is split into LANES samples of LANE_W bits.
package vec_stream_pkg;

  localparam int LANE_W = 8;
  localparam int LANES  = 16;
  localparam int VEC_W  = 128;

  typedef logic [LANE_W-1:0] lane_t;
  typedef logic [VEC_W-1:0]  vec_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } ser_state_t;

endpackage

// File: rtl/vec_sync_fifo.sv
// Single-clock FIFO of 128-bit vector words with registered count, full and empty flags.
// A push and a pop in the same cycle are both honoured.
module vec_sync_fifo
  import vec_stream_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  vec_t             wdata,
  input  logic             pop,
  output vec_t             rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  vec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             full_reg;
  logic             empty_reg;
  logic             push_ok;
  logic             pop_ok;

  // Gating on the registered flags means a pop in the same cycle cannot make room for a push.
  assign push_ok    = push && !full_reg;
  assign pop_ok     = pop && !empty_reg;
  assign count_next = count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CNT_W'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  // The head word must be available in the same cycle the serializer decides to load it.
  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = full_reg;
  assign empty = empty_reg;

endmodule

// File: rtl/vec_lane_serializer.sv
// Buffers vector store words and streams them out lane by lane, lane 0 first, on a valid/ready port.
// Words arriving while the buffer is full are dropped and latched into a sticky overflow flag.
module vec_lane_serializer #(
  parameter int LANE_W = vec_stream_pkg::LANE_W,
  parameter int LANES  = vec_stream_pkg::LANES,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wren_b,
  input  logic [127:0]               data_b,
  output logic [LANE_W-1:0]          sample_out,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       sample_last,
  output logic [$clog2(LANES)-1:0]   lane_idx,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow,
  input  logic                       clr_overflow
);

  import vec_stream_pkg::*;

  localparam int LIDX_W = $clog2(LANES);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  ser_state_t        state_reg;
  ser_state_t        state_next;
  vec_t              word_reg;
  vec_t              word_next;
  logic [LIDX_W-1:0] lane_idx_reg;
  logic [LIDX_W-1:0] lane_idx_next;
  logic              overflow_reg;
  logic              pop;
  vec_t              head;
  logic              fifo_empty;
  logic              fifo_full;
  logic [CNT_W-1:0]  count;
  logic              at_last;
  logic [LANE_W-1:0] lanes [LANES];

  vec_sync_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .srst  (reset),
    .push  (wren_b),
    .wdata (data_b),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lanes[gi] = word_reg[gi*LANE_W +: LANE_W];
  end

  assign at_last = (lane_idx_reg == LIDX_W'(LANES - 1));

  always_comb begin
    state_next    = state_reg;
    word_next     = word_reg;
    lane_idx_next = lane_idx_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop           = 1'b1;
          word_next     = head;
          lane_idx_next = '0;
          state_next    = STREAM;
        end
      end
      STREAM: begin
        if (sample_ready) begin
          if (!at_last) begin
            lane_idx_next = lane_idx_reg + LIDX_W'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next word so the stream has no bubble at word boundaries.
            pop           = 1'b1;
            word_next     = head;
            lane_idx_next = '0;
          end else begin
            lane_idx_next = '0;
            state_next    = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      word_reg     <= '0;
      lane_idx_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      word_reg     <= word_next;
      lane_idx_reg <= lane_idx_next;
      // A drop on the same edge as a clear still leaves the flag set.
      if (wren_b && fifo_full) begin
        overflow_reg <= 1'b1;
      end else if (clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign sample_valid = (state_reg == STREAM);
  assign sample_out   = sample_valid ? lanes[lane_idx_reg] : '0;
  assign sample_last  = sample_valid && at_last;
  assign lane_idx     = lane_idx_reg;
  assign fifo_count   = count;
  assign full         = fifo_full;
  assign empty        = fifo_empty && (state_reg == IDLE);
  assign overflow     = overflow_reg;

endmodule

// File: tb/tb_vec_lane_serializer.sv
// Directed and random stimulus for vec_lane_serializer, checked every cycle against a queue-based model.
module tb_vec_lane_serializer;

  localparam int DEPTH = 4;
  localparam int LANES = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         wren_b;
  logic [127:0] data_b;
  logic [7:0]   sample_out;
  logic         sample_valid;
  logic         sample_ready;
  logic         sample_last;
  logic [3:0]   lane_idx;
  logic [2:0]   fifo_count;
  logic         full;
  logic         empty;
  logic         overflow;
  logic         clr_overflow;

  int checks = 0;
  int errors = 0;

  // Model state: words waiting, the word being streamed, and the lanes still owed to the sink.
  logic [127:0] m_fifo [$];
  logic [7:0]   m_owed [$];
  bit           m_busy;
  logic [127:0] m_word;
  int           m_lane;
  bit           m_ovf;
  int           emitted;

  vec_lane_serializer #(.LANE_W(8), .LANES(16), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wren_b       (wren_b),
    .data_b       (data_b),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_last  (sample_last),
    .lane_idx     (lane_idx),
    .fifo_count   (fifo_count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [7:0] exp_sample;
    exp_sample = m_busy ? m_word[m_lane*8 +: 8] : 8'h00;
    chk("sample_valid", 128'(sample_valid), 128'(m_busy));
    chk("sample_out",   128'(sample_out),   128'(exp_sample));
    chk("sample_last",  128'(sample_last),  128'(m_busy && m_lane == LANES - 1));
    chk("lane_idx",     128'(lane_idx),     128'(m_lane));
    chk("fifo_count",   128'(fifo_count),   128'(m_fifo.size()));
    chk("full",         128'(full),         128'(m_fifo.size() == DEPTH));
    chk("empty",        128'(empty),        128'(m_fifo.size() == 0 && !m_busy));
    chk("overflow",     128'(overflow),     128'(m_ovf));
  endtask

  // One clock: drive inputs, score any handshake, advance the model, then compare after the edge.
  task automatic step(input bit wr, input logic [127:0] data, input bit rdy,
                      input bit clr, input bit rst);
    bit accept;
    bit had_words;
    bit was_full;
    logic [7:0] want;
    wren_b = wr; data_b = data; sample_ready = rdy; clr_overflow = clr; reset = rst;
    accept = m_busy && rdy;
    if (!rst && sample_valid && rdy) begin
      if (m_owed.size() == 0) begin
        chk("unexpected_lane", 128'(sample_out), 128'hDEAD);
      end else begin
        want = m_owed.pop_front();
        chk("lane_stream", 128'(sample_out), 128'(want));
        emitted++;
      end
    end
    @(posedge clk);
    if (rst) begin
      m_fifo.delete(); m_owed.delete();
      m_busy = 0; m_word = '0; m_lane = 0; m_ovf = 0;
    end else begin
      had_words = m_fifo.size() > 0;
      was_full  = m_fifo.size() == DEPTH;
      if (!m_busy) begin
        if (had_words) begin m_word = m_fifo.pop_front(); m_lane = 0; m_busy = 1; end
      end else if (accept) begin
        if (m_lane < LANES - 1) m_lane++;
        else if (had_words) begin m_word = m_fifo.pop_front(); m_lane = 0; end
        else begin m_busy = 0; m_lane = 0; end
      end
      if (wr && was_full) m_ovf = 1;
      else begin
        if (wr) begin
          m_fifo.push_back(data);
          for (int k = 0; k < LANES; k++) m_owed.push_back(data[k*8 +: 8]);
        end
        if (clr) m_ovf = 0;
      end
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] ramp;
    int guard;
    wren_b = 0; data_b = '0; sample_ready = 0; clr_overflow = 0; reset = 1;
    m_busy = 0; m_word = '0; m_lane = 0; m_ovf = 0; emitted = 0;
    @(negedge clk);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);

    // Single ramp word, lane k carries value k.
    for (int k = 0; k < LANES; k++) ramp[k*8 +: 8] = 8'(k);
    step(1, ramp, 1, 0, 0);
    for (int c = 0; c < 20; c++) step(0, '0, 1, 0, 0);
    chk("single_emitted", 128'(emitted), 128'(16));

    // Back-to-back words with ready held high.
    emitted = 0;
    step(1, rand_word(), 1, 0, 0);
    step(1, rand_word(), 1, 0, 0);
    for (int c = 0; c < 36; c++) step(0, '0, 1, 0, 0);
    chk("b2b_emitted", 128'(emitted), 128'(32));

    // Backpressure pattern 1,0,0,1 over one word.
    emitted = 0;
    step(1, rand_word(), 0, 0, 0);
    for (int c = 0; c < 80; c++) step(0, '0, (c % 4 == 0) || (c % 4 == 3), 0, 0);
    chk("bp_emitted", 128'(emitted), 128'(16));

    // Six writes while stalled: five kept, sixth dropped.
    emitted = 0;
    for (int w = 0; w < 6; w++) step(1, rand_word(), 0, 0, 0);
    for (int c = 0; c < 90; c++) step(0, '0, 1, 0, 0);
    chk("ovf_emitted", 128'(emitted), 128'(80));
    step(0, '0, 0, 1, 0);

    // Fill everything, then write on the edge where the last lane is accepted.
    for (int w = 0; w < 5; w++) step(1, rand_word(), 0, 0, 0);
    for (int c = 0; c < 15; c++) step(0, '0, 1, 0, 0);
    step(1, rand_word(), 1, 0, 0);
    for (int c = 0; c < 70; c++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 0);

    // Reset while lane 7 of a word is presented and two more are queued.
    for (int w = 0; w < 3; w++) step(1, rand_word(), 1, 0, 0);
    guard = 0;
    while (m_lane != 7 && guard < 40) begin step(0, '0, 1, 0, 0); guard++; end
    chk("reached_lane7", 128'(lane_idx), 128'(7));
    step(0, '0, 1, 0, 1);
    emitted = 0;
    for (int c = 0; c < 10; c++) step(0, '0, 1, 0, 0);
    chk("post_reset_emitted", 128'(emitted), 128'(0));

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      step($urandom_range(0, 3) == 0, rand_word(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 15) == 0, $urandom_range(0, 299) == 0);
    end
    for (int c = 0; c < 120; c++) step(0, '0, 1, 0, 0);
    chk("drain_owed", 128'(m_owed.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
